halton_batch_sched: RTL and testbench
=====================================

Name: halton_batch_sched

Overview:
Batch scheduler that drives one halton_fsm_32bit_simple engine through its start/ready/done handshake. It issues consecutive indices k = k_start … k_start+count-1 for one base pair. Each result is buffered in a small output FIFO and presented as a valid/ready stream of 16.16 fixed-point (x, y, k) points. It sits between the host or config registers and the Halton engine, decoupling engine latency from downstream backpressure.

Parameters:
FIFO_DEPTH, 4, output FIFO entries; power of two, 2..16.
CNT_W, 16, width of batch count.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cfg_k_start  in  32  first index of batch
cfg_count  in  CNT_W  number of points in batch
cfg_base0_sel  in  2  base for x: 00=2, 01=3, 10=7, 11=illegal
cfg_base1_sel  in  2  base for y, same encoding
go  in  1  single-cycle batch request; cfg_* sampled in the same cycle
abort  in  1  single-cycle cancel request
busy  out  1  high from go acceptance until return to IDLE
batch_done  out  1  one-cycle pulse at normal batch completion
cfg_err  out  1  sticky illegal-select flag
eng_start  out  1  engine start pulse
eng_k  out  32  engine k_in
eng_base0_sel  out  2  engine base0_sel
eng_base1_sel  out  2  engine base1_sel
eng_result_x  in  32  engine result_x
eng_result_y  in  32  engine result_y
eng_done  in  1  engine done
eng_ready  in  1  engine ready
out_valid  out  1  FIFO head valid
out_ready  in  1  downstream accept
out_x  out  32  x, 16.16
out_y  out  32  y, 16.16
out_k  out  32  index of this point
out_last  out  1  final point of batch
perf_cycles  out  32  batch cycle count (optional feature)

Behaviour:
- Reset values: all outputs 0. FSM goes to IDLE, FIFO is emptied, cfg_err cleared.
- Clock and reset: one clock clk; reset rst_n is asynchronous, active-low. rst_n mid-batch aborts immediately; the engine shares rst_n.
- States: IDLE, ISSUE, WAIT_DONE, DRAIN, ABORT_WAIT.
- IDLE, go with either sel = 11: no issue; cfg_err = 1 next cycle; stays IDLE.
- IDLE, go with count = 0 and legal sels: batch_done pulses the next cycle; no eng_start.
- IDLE, go otherwise:
  - cfg_err cleared.
  - eng_k, eng_base*_sel and the remaining-count are latched.
  - busy = 1; next state ISSUE.
- go while busy: ignored.
- ISSUE:
  - Waits for eng_ready = 1 and FIFO occupancy < FIFO_DEPTH.
  - eng_start is registered: high for exactly one cycle, the cycle after the condition holds; then WAIT_DONE.
  - At most one request is outstanding, so a push never overflows.
- WAIT_DONE, eng_done = 1:
  - Push {eng_result_x, eng_result_y, eng_k, last} in that cycle.
  - If the point is the last: go to DRAIN.
  - Otherwise: eng_k += 1 (32-bit wrap, 0xFFFFFFFF→0) and return to ISSUE.
- eng_k and eng_base*_sel stay stable from latch until the next eng_done.
- DRAIN: when the FIFO becomes empty (last point popped), pulse batch_done, busy = 0, return to IDLE.
- FIFO:
  - out_valid = !empty; pop on out_valid && out_ready.
  - A pushed entry is visible on the outputs the cycle after eng_done.
  - Simultaneous push and pop leaves occupancy unchanged; order is strictly preserved.
  - out_* hold stable while out_valid && !out_ready.
- abort (busy only):
  - In ISSUE or DRAIN: flush the FIFO next cycle and go to IDLE.
  - In WAIT_DONE: go to ABORT_WAIT; the in-flight result is discarded on eng_done, then flush and go to IDLE.
  - abort never produces a batch_done pulse.
  - abort in IDLE: ignored.
  - If abort and eng_done occur in the same cycle, abort wins and the result is discarded.

Optional Feature:
HALTON_SCHED_PERF_EN
- Defined:
  - perf_cycles clears on go acceptance and increments every cycle while busy.
  - It freezes when batch_done pulses (the pulse cycle is included) and holds until the next accepted go.
  - After an abort it holds the partial count.
- Undefined: the port exists and is tied to 0.

Test Plan:
- Bases [2,3], k_start=1, count=4, out_ready=1 → x = 8000, 4000, C000, 2000 and y = 5555, AAAA, 1C71, 71C7 (hex, ±0x100); out_k = 1..4; out_last only on the 4th point; exactly one batch_done.
- Bases [3,7], k_start=1, count=6, out_ready=0 → exactly 4 eng_start pulses, then stall. Raise out_ready → 6 points in order; x[0] = 5555, y[0] = 2492, y[4] = B6DB.
- count=0, and separately sel0=11 → count=0 gives batch_done one cycle after go with no eng_start. sel0=11 gives cfg_err = 1, busy stays 0, and cfg_err clears on the next legal go.
- k_start=0xFFFFFFFF, count=2, bases [2,3] → out_k = FFFFFFFF, then 00000000 with x = 0.
- abort asserted during WAIT_DONE of the 3rd point, count=8 → no batch_done; out_valid = 0 after flush; busy falls after eng_done; the next go works normally.
- rst_n low mid-batch → all outputs 0 immediately; FIFO empty. With HALTON_SCHED_PERF_EN, a count=4 batch with out_ready=1 gives a nonzero perf_cycles equal to the go-to-batch_done span.

Source files
------------

// File: rtl/halton_batch_sched.sv
// Batch scheduler that feeds consecutive indices to a Halton engine and streams the results out of a small FIFO.
// Optional cycle counter on perf_cycles when HALTON_SCHED_PERF_EN is defined; otherwise perf_cycles is tied to 0.
module halton_batch_sched #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      cfg_k_start,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic [1:0]       cfg_base0_sel,
    input  logic [1:0]       cfg_base1_sel,
    input  logic             go,
    input  logic             abort,
    output logic             busy,
    output logic             batch_done,
    output logic             cfg_err,
    output logic             eng_start,
    output logic [31:0]      eng_k,
    output logic [1:0]       eng_base0_sel,
    output logic [1:0]       eng_base1_sel,
    input  logic [31:0]      eng_result_x,
    input  logic [31:0]      eng_result_y,
    input  logic             eng_done,
    input  logic             eng_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_x,
    output logic [31:0]      out_y,
    output logic [31:0]      out_k,
    output logic             out_last,
    output logic [31:0]      perf_cycles
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_OCC = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0] ONE_OCC  = (PTR_W + 1)'(1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, DRAIN, ABORT_WAIT} state_t;
    state_t state, next_state;

    logic [CNT_W-1:0] remaining;
    logic [31:0]      fifo_x [FIFO_DEPTH];
    logic [31:0]      fifo_y [FIFO_DEPTH];
    logic [31:0]      fifo_k [FIFO_DEPTH];
    logic             fifo_last [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   occ;

    logic sel_illegal, is_last, pop, push, flush;
    logic latch_cfg, advance, start_set, done_set, err_set, err_clr;

    assign sel_illegal = (cfg_base0_sel == 2'b11) || (cfg_base1_sel == 2'b11);
    assign is_last     = (remaining == CNT_W'(1));
    assign out_valid   = (occ != '0);
    assign pop         = out_valid && out_ready;
    assign busy        = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        latch_cfg  = 1'b0;
        advance    = 1'b0;
        start_set  = 1'b0;
        done_set   = 1'b0;
        err_set    = 1'b0;
        err_clr    = 1'b0;
        push       = 1'b0;
        flush      = 1'b0;
        case (state)
            IDLE: begin
                if (go) begin
                    if (sel_illegal) begin
                        err_set = 1'b1;
                    end else if (cfg_count == '0) begin
                        done_set = 1'b1;
                    end else begin
                        err_clr    = 1'b1;
                        latch_cfg  = 1'b1;
                        next_state = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (abort) begin
                    flush      = 1'b1;
                    next_state = IDLE;
                end else if (eng_ready && (occ != FULL_OCC)) begin
                    start_set  = 1'b1;
                    next_state = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                // An abort coinciding with eng_done discards the result; nothing is left in flight.
                if (abort) begin
                    if (eng_done) begin
                        flush      = 1'b1;
                        next_state = IDLE;
                    end else begin
                        next_state = ABORT_WAIT;
                    end
                end else if (eng_done) begin
                    push = 1'b1;
                    if (is_last) begin
                        next_state = DRAIN;
                    end else begin
                        advance    = 1'b1;
                        next_state = ISSUE;
                    end
                end
            end
            DRAIN: begin
                if (abort) begin
                    flush      = 1'b1;
                    next_state = IDLE;
                end else if (!out_valid || (occ == ONE_OCC && pop)) begin
                    done_set   = 1'b1;
                    next_state = IDLE;
                end
            end
            ABORT_WAIT: begin
                if (eng_done) begin
                    flush      = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_k         <= '0;
            eng_base0_sel <= '0;
            eng_base1_sel <= '0;
            remaining     <= '0;
            eng_start     <= 1'b0;
            batch_done    <= 1'b0;
            cfg_err       <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            occ           <= '0;
        end else begin
            eng_start  <= start_set;
            batch_done <= done_set;
            if (err_set)      cfg_err <= 1'b1;
            else if (err_clr) cfg_err <= 1'b0;
            if (latch_cfg) begin
                eng_k         <= cfg_k_start;
                eng_base0_sel <= cfg_base0_sel;
                eng_base1_sel <= cfg_base1_sel;
                remaining     <= cfg_count;
            end else if (advance) begin
                eng_k     <= eng_k + 32'd1;
                remaining <= remaining - CNT_W'(1);
            end
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                occ    <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                if (push && !pop)      occ <= occ + 1'b1;
                else if (!push && pop) occ <= occ - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_x[wr_ptr]    <= eng_result_x;
            fifo_y[wr_ptr]    <= eng_result_y;
            fifo_k[wr_ptr]    <= eng_k;
            fifo_last[wr_ptr] <= is_last;
        end
    end

    // Storage is not reset, so the head is masked to keep the outputs at 0 whenever empty.
    assign out_x    = out_valid ? fifo_x[rd_ptr]    : '0;
    assign out_y    = out_valid ? fifo_y[rd_ptr]    : '0;
    assign out_k    = out_valid ? fifo_k[rd_ptr]    : '0;
    assign out_last = out_valid ? fifo_last[rd_ptr] : 1'b0;

`ifdef HALTON_SCHED_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                  perf_q <= '0;
        else if (state == IDLE && go && !sel_illegal) perf_q <= '0;
        else if (busy || batch_done)                 perf_q <= perf_q + 32'd1;
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_halton_batch_sched.sv
// Directed bench for halton_batch_sched with a behavioural Halton engine (fixed latency, exact radical inverse).
module tb_halton_batch_sched;

    localparam int ENG_LAT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] cfg_k_start = '0;
    logic [15:0] cfg_count = '0;
    logic [1:0]  cfg_base0_sel = '0;
    logic [1:0]  cfg_base1_sel = '0;
    logic        go = 1'b0;
    logic        abort = 1'b0;
    logic        busy, batch_done, cfg_err, eng_start;
    logic [31:0] eng_k;
    logic [1:0]  eng_base0_sel, eng_base1_sel;
    logic [31:0] eng_result_x, eng_result_y;
    logic        eng_done, eng_ready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_x, out_y, out_k;
    logic        out_last;
    logic [31:0] perf_cycles;

    int errors = 0;
    int checks = 0;
    int start_cnt = 0;
    int done_cnt = 0;
    int cyc = 0;

    halton_batch_sched #(.FIFO_DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_k_start(cfg_k_start), .cfg_count(cfg_count),
        .cfg_base0_sel(cfg_base0_sel), .cfg_base1_sel(cfg_base1_sel),
        .go(go), .abort(abort),
        .busy(busy), .batch_done(batch_done), .cfg_err(cfg_err),
        .eng_start(eng_start), .eng_k(eng_k),
        .eng_base0_sel(eng_base0_sel), .eng_base1_sel(eng_base1_sel),
        .eng_result_x(eng_result_x), .eng_result_y(eng_result_y),
        .eng_done(eng_done), .eng_ready(eng_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_k(out_k), .out_last(out_last),
        .perf_cycles(perf_cycles)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (eng_start)  start_cnt <= start_cnt + 1;
        if (batch_done) done_cnt  <= done_cnt + 1;
    end

    function automatic logic [31:0] rinv(input logic [31:0] k, input logic [1:0] sel);
        longint unsigned b, num, den, kk;
        b   = (sel == 2'b00) ? 2 : (sel == 2'b01) ? 3 : 7;
        num = 0;
        den = 1;
        kk  = k;
        while (kk != 0) begin
            num = num * b + kk % b;
            den = den * b;
            kk  = kk / b;
        end
        return 32'((num << 16) / den);
    endfunction

    logic [31:0] m_k;
    logic [1:0]  m_b0, m_b1;
    int          m_lat;

    // Engine model: accepts a start while ready, answers ENG_LAT cycles later with a one-cycle done.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_ready    <= 1'b1;
            eng_done     <= 1'b0;
            eng_result_x <= '0;
            eng_result_y <= '0;
            m_lat        <= 0;
        end else begin
            eng_done <= 1'b0;
            if (eng_ready && eng_start) begin
                eng_ready <= 1'b0;
                m_k       <= eng_k;
                m_b0      <= eng_base0_sel;
                m_b1      <= eng_base1_sel;
                m_lat     <= ENG_LAT;
            end else if (!eng_ready) begin
                if (m_lat == 1) begin
                    eng_done     <= 1'b1;
                    eng_result_x <= rinv(m_k, m_b0);
                    eng_result_y <= rinv(m_k, m_b1);
                    eng_ready    <= 1'b1;
                end else begin
                    m_lat <= m_lat - 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] k0, input logic [15:0] n,
                                 input logic [1:0] s0, input logic [1:0] s1);
        cfg_k_start   = k0;
        cfg_count     = n;
        cfg_base0_sel = s0;
        cfg_base1_sel = s1;
        go            = 1'b1;
        tick();
        go = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        int t = 0;
        while (!out_valid && t < 200) begin
            tick();
            t++;
        end
        ok = out_valid;
    endtask

    task automatic wait_idle(output bit ok);
        int t = 0;
        while (busy && t < 500) begin
            tick();
            t++;
        end
        ok = !busy;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || batch_done !== 1'b0 || cfg_err !== 1'b0 || eng_start !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: busy=%b done=%b err=%b start=%b want all 0", busy, batch_done, cfg_err, eng_start);
        end
        checks++;
        if (out_valid !== 1'b0 || out_x !== 32'h0 || out_k !== 32'h0 || eng_k !== 32'h0 || perf_cycles !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_data: valid=%b x=%h k=%h eng_k=%h perf=%h want all 0", out_valid, out_x, out_k, eng_k, perf_cycles);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [31:0] ex [4];
        logic [31:0] ey [4];
        int d0;
        bit ok;
        ex = '{32'h8000, 32'h4000, 32'hC000, 32'h2000};
        ey = '{32'h5555, 32'hAAAA, 32'h1C71, 32'h71C7};
        d0 = done_cnt;
        out_ready = 1'b1;
        applyStimulus(32'd1, 16'd4, 2'b00, 2'b01);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL basic_busy: got %b want 1", busy);
        end
        for (int i = 0; i < 4; i++) begin
            wait_valid(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("[TB] FAIL basic_timeout%0d: out_valid got 0 want 1", i);
            end
            checks++;
            if (int'(out_x) > int'(ex[i]) + 256 || int'(out_x) + 256 < int'(ex[i])) begin
                errors++;
                $display("[TB] FAIL basic_x%0d: got %h want %h", i, out_x, ex[i]);
            end
            checks++;
            if (int'(out_y) > int'(ey[i]) + 256 || int'(out_y) + 256 < int'(ey[i])) begin
                errors++;
                $display("[TB] FAIL basic_y%0d: got %h want %h", i, out_y, ey[i]);
            end
            checks++;
            if (out_k !== 32'(i + 1) || out_last !== (i == 3)) begin
                errors++;
                $display("[TB] FAIL basic_k%0d: got k=%h last=%b want k=%h last=%b", i, out_k, out_last, i + 1, i == 3);
            end
            tick();
        end
        wait_idle(ok);
        tick();
        tick();
        checks++;
        if (!ok || done_cnt - d0 != 1) begin
            errors++;
            $display("[TB] FAIL basic_done: idle=%b pulses=%0d want idle=1 pulses=1", ok, done_cnt - d0);
        end
    endtask

    task automatic test_backpressure();
        int s0;
        bit ok;
        logic [31:0] k_hold;
        logic [31:0] xs [6];
        logic [31:0] ys [6];
        logic [31:0] ks [6];
        s0 = start_cnt;
        out_ready = 1'b0;
        applyStimulus(32'd1, 16'd6, 2'b01, 2'b10);
        for (int i = 0; i < 60; i++) tick();
        k_hold = out_k;
        applyStimulus(32'd100, 16'd3, 2'b00, 2'b00);
        for (int i = 0; i < 20; i++) tick();
        checks++;
        if (start_cnt - s0 != 4) begin
            errors++;
            $display("[TB] FAIL bp_starts: got %0d want 4", start_cnt - s0);
        end
        checks++;
        if (out_valid !== 1'b1 || busy !== 1'b1 || out_k !== 32'd1 || k_hold !== 32'd1) begin
            errors++;
            $display("[TB] FAIL bp_stall: valid=%b busy=%b k=%h held=%h want 1 1 1 1", out_valid, busy, out_k, k_hold);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_valid(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("[TB] FAIL bp_timeout%0d: out_valid got 0 want 1", i);
            end
            xs[i] = out_x;
            ys[i] = out_y;
            ks[i] = out_k;
            tick();
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (ks[i] !== 32'(i + 1)) begin
                errors++;
                $display("[TB] FAIL bp_k%0d: got %h want %h", i, ks[i], i + 1);
            end
        end
        checks++;
        if (int'(xs[0]) > 32'h5555 + 256 || int'(xs[0]) + 256 < 32'h5555) begin
            errors++;
            $display("[TB] FAIL bp_x0: got %h want 5555", xs[0]);
        end
        checks++;
        if (int'(ys[0]) > 32'h2492 + 256 || int'(ys[0]) + 256 < 32'h2492) begin
            errors++;
            $display("[TB] FAIL bp_y0: got %h want 2492", ys[0]);
        end
        checks++;
        if (int'(ys[4]) > 32'hB6DB + 256 || int'(ys[4]) + 256 < 32'hB6DB) begin
            errors++;
            $display("[TB] FAIL bp_y4: got %h want B6DB", ys[4]);
        end
        wait_idle(ok);
        tick();
    endtask

    task automatic test_count_zero();
        int s0;
        s0 = start_cnt;
        applyStimulus(32'd5, 16'd0, 2'b00, 2'b01);
        checks++;
        if (batch_done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL zero_done: done=%b busy=%b want 1 0", batch_done, busy);
        end
        tick();
        tick();
        checks++;
        if (batch_done !== 1'b0 || start_cnt != s0) begin
            errors++;
            $display("[TB] FAIL zero_after: done=%b starts=%0d want 0 0", batch_done, start_cnt - s0);
        end
    endtask

    task automatic test_cfg_err();
        int s0;
        bit ok;
        s0 = start_cnt;
        applyStimulus(32'd1, 16'd3, 2'b11, 2'b00);
        tick();
        tick();
        checks++;
        if (cfg_err !== 1'b1 || busy !== 1'b0 || start_cnt != s0) begin
            errors++;
            $display("[TB] FAIL err_set: err=%b busy=%b starts=%0d want 1 0 0", cfg_err, busy, start_cnt - s0);
        end
        out_ready = 1'b1;
        applyStimulus(32'd1, 16'd1, 2'b00, 2'b00);
        checks++;
        if (cfg_err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL err_clear: err=%b busy=%b want 0 1", cfg_err, busy);
        end
        wait_idle(ok);
        tick();
    endtask

    task automatic test_wrap();
        bit ok;
        out_ready = 1'b1;
        applyStimulus(32'hFFFF_FFFF, 16'd2, 2'b00, 2'b01);
        wait_valid(ok);
        checks++;
        if (!ok || out_k !== 32'hFFFF_FFFF || out_last !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wrap_first: valid=%b k=%h last=%b want 1 FFFFFFFF 0", ok, out_k, out_last);
        end
        tick();
        wait_valid(ok);
        checks++;
        if (!ok || out_k !== 32'h0 || out_x !== 32'h0 || out_last !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wrap_second: valid=%b k=%h x=%h last=%b want 1 0 0 1", ok, out_k, out_x, out_last);
        end
        tick();
        wait_idle(ok);
        tick();
    endtask

    task automatic test_abort();
        int s0, d0, t;
        bit ok;
        s0 = start_cnt;
        d0 = done_cnt;
        out_ready = 1'b0;
        applyStimulus(32'd1, 16'd8, 2'b00, 2'b01);
        t = 0;
        while (start_cnt - s0 < 3 && t < 200) begin
            tick();
            t++;
        end
        checks++;
        if (start_cnt - s0 != 3 || out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_setup: starts=%0d valid=%b want 3 1", start_cnt - s0, out_valid);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_inflight: busy=%b want 1", busy);
        end
        wait_idle(ok);
        tick();
        tick();
        checks++;
        if (!ok || out_valid !== 1'b0 || done_cnt != d0 || start_cnt - s0 != 3) begin
            errors++;
            $display("[TB] FAIL abort_flush: idle=%b valid=%b done=%0d starts=%0d want 1 0 0 3", ok, out_valid, done_cnt - d0, start_cnt - s0);
        end
        d0 = done_cnt;
        out_ready = 1'b1;
        applyStimulus(32'd3, 16'd2, 2'b00, 2'b01);
        wait_valid(ok);
        checks++;
        if (!ok || out_k !== 32'd3 || int'(out_x) > 32'hC000 + 256 || int'(out_x) + 256 < 32'hC000) begin
            errors++;
            $display("[TB] FAIL abort_next: valid=%b k=%h x=%h want 1 3 C000", ok, out_k, out_x);
        end
        tick();
        wait_idle(ok);
        tick();
        tick();
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("[TB] FAIL abort_next_done: got %0d want 1", done_cnt - d0);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        out_ready = 1'b0;
        applyStimulus(32'd1, 16'd4, 2'b00, 2'b01);
        wait_valid(ok);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (!ok || busy !== 1'b0 || out_valid !== 1'b0 || out_x !== 32'h0 || out_k !== 32'h0 || eng_k !== 32'h0 || eng_start !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid: saw=%b busy=%b valid=%b x=%h k=%h eng_k=%h start=%b want 1 0 0 0 0 0 0",
                     ok, busy, out_valid, out_x, out_k, eng_k, eng_start);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_perf();
        int c_go, c_done, t;
        bit ok;
        out_ready = 1'b1;
        c_go = cyc;
        applyStimulus(32'd1, 16'd4, 2'b00, 2'b01);
        t = 0;
        while (batch_done !== 1'b1 && t < 300) begin
            tick();
            t++;
        end
        c_done = cyc;
        checks++;
        if (batch_done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL perf_timeout: batch_done got 0 want 1");
        end
        tick();
        tick();
        wait_idle(ok);
`ifdef HALTON_SCHED_PERF_EN
        checks++;
        if (perf_cycles !== 32'(c_done - c_go) || perf_cycles == 32'd0) begin
            errors++;
            $display("[TB] FAIL perf_span: got %0d want %0d", perf_cycles, c_done - c_go);
        end
`else
        checks++;
        if (perf_cycles !== 32'd0) begin
            errors++;
            $display("[TB] FAIL perf_tied: got %0d want 0 (span %0d)", perf_cycles, c_done - c_go);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_count_zero();
        test_cfg_err();
        test_wrap();
        test_abort();
        test_reset_mid();
        test_perf();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
